fwft_word_packer: RTL and testbench

- Sink-side stage that sits directly downstream of an FWFT FIFO.
- It pops narrow words through the FIFO's empty/read_en/read_data interface and packs RATIO consecutive words into one wide output word.
- The wide word is presented on a valid/ready stream with per-lane keep bits.
- A flush request emits a partially filled word, so stream tails are never stranded in the packer.

---
 rtl/fwft_word_packer.sv | 153 +++++++++++++++
 tb/tb_fwft_word_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_word_packer.sv
// Packs ratio narrow words popped from an FWFT FIFO into one wide valid/ready word with lane keep bits.
// Define FWFT_WORD_PACKER_STATS_EN to add the word_count/partial_count statistics outputs.
module fwft_word_packer #(
  parameter int in_width    = 8,
  parameter int ratio       = 4,
  parameter int lanewidthad = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      in_empty,
  output logic                      in_read_en,
  input  logic [in_width-1:0]       in_read_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [in_width*ratio-1:0] out_data,
  output logic [ratio-1:0]          out_keep,
  output logic                      busy
`ifdef FWFT_WORD_PACKER_STATS_EN
  ,
  output logic [31:0]               word_count,
  output logic [15:0]               partial_count
`endif
);

  localparam logic [lanewidthad-1:0] LAST = lanewidthad'(ratio - 1);

  logic [lanewidthad-1:0]           lane_q, lane_d;
  logic [ratio-1:0][in_width-1:0]   acc_q, acc_d;
  logic [ratio-1:0][in_width-1:0]   out_data_q, out_data_d;
  logic [ratio-1:0]                 out_keep_q, out_keep_d;
  logic                             out_valid_q, out_valid_d;
  logic                             flush_pending_q, flush_pending_d;
  logic                             slot_free, accept, hs;

  // The last lane may only pop when the output register can take the finished word.
  assign slot_free  = ~out_valid_q | out_ready;
  assign in_read_en = reset & clken & ~in_empty & ~flush_pending_q &
                      ((lane_q != LAST) | slot_free);
  assign accept     = in_read_en;
  assign hs         = out_valid_q & out_ready & clken;

  always_comb begin
    lane_d          = lane_q;
    acc_d           = acc_q;
    out_data_d      = out_data_q;
    out_keep_d      = out_keep_q;
    out_valid_d     = out_valid_q;
    flush_pending_d = flush_pending_q;
    if (clken) begin
      if (hs) out_valid_d = 1'b0;
      if (accept) begin
        if (lane_q != LAST) begin
          for (int i = 0; i < ratio - 1; i++)
            if (lane_q == lanewidthad'(i)) acc_d[i] = in_read_data;
          lane_d = lane_q + 1'b1;
        end else begin
          out_data_d          = acc_q;
          out_data_d[ratio-1] = in_read_data;
          out_keep_d          = '1;
          out_valid_d         = 1'b1;
          lane_d              = '0;
          acc_d               = '0;
        end
      end
      // No pops happen while a flush is pending, so acc is exactly the tail to emit.
      if (flush_pending_q) begin
        if (lane_q == '0) begin
          flush_pending_d = 1'b0;
        end else if (slot_free) begin
          out_data_d = acc_q;
          for (int i = 0; i < ratio; i++)
            out_keep_d[i] = (lanewidthad'(i) < lane_q);
          out_valid_d     = 1'b1;
          lane_d          = '0;
          acc_d           = '0;
          flush_pending_d = 1'b0;
        end
      end else if (flush) begin
        flush_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q          <= '0;
      acc_q           <= '0;
      out_data_q      <= '0;
      out_keep_q      <= '0;
      out_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      lane_q          <= lane_d;
      acc_q           <= acc_d;
      out_data_q      <= out_data_d;
      out_keep_q      <= out_keep_d;
      out_valid_q     <= out_valid_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign busy      = (lane_q != '0) | flush_pending_q | out_valid_q;

`ifdef FWFT_WORD_PACKER_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [15:0] partial_count_q, partial_count_d;

  always_comb begin
    word_count_d    = word_count_q;
    partial_count_d = partial_count_q;
    if (hs) begin
      word_count_d = word_count_q + 32'd1;
      if (!(&out_keep_q) && partial_count_q != 16'hFFFF)
        partial_count_d = partial_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count_q    <= '0;
      partial_count_q <= '0;
    end else begin
      word_count_q    <= word_count_d;
      partial_count_q <= partial_count_d;
    end
  end

  assign word_count    = word_count_q;
  assign partial_count = partial_count_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(in_read_en && in_empty)) else $error("pop while FIFO empty");
      assert (lane_q <= LAST) else $error("lane counter out of range");
    end
  end

  if (lanewidthad < $clog2(ratio) || ratio < 2 || ratio > 16) begin : g_bad_param
    always @(posedge clk) begin
      $error("illegal ratio/lanewidthad combination");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_fwft_word_packer.sv
// Bench for fwft_word_packer: directed scenarios plus randomized traffic against a queue-based packing model.
module tb_fwft_word_packer;

  logic        clk = 1'b0;
  logic        reset, clken, in_empty, in_read_en, flush, out_valid, out_ready, busy;
  logic [7:0]  in_read_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
`ifdef FWFT_WORD_PACKER_STATS_EN
  logic [31:0] word_count;
  logic [15:0] partial_count;
`endif

  always #5 clk = ~clk;

  fwft_word_packer dut (
    .clk(clk), .reset(reset), .clken(clken), .in_empty(in_empty),
    .in_read_en(in_read_en), .in_read_data(in_read_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .busy(busy)
`ifdef FWFT_WORD_PACKER_STATS_EN
    , .word_count(word_count), .partial_count(partial_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo[$];
  logic [7:0]  cur[$];
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];
  int          exp_partials, obs_partials, illegal_pops;

  bit          s_rd, s_vld, s_busy, s_hs;
  logic [31:0] s_data;
  logic [3:0]  s_keep;

  // Reference: every popped byte joins the current group; 4 bytes make a full word,
  // a flush turns any non-empty group into a partial word.
  function automatic void model_pop(input logic [7:0] b);
    cur.push_back(b);
    if (cur.size() == 4) begin
      exp_q.push_back({4'hF, cur[3], cur[2], cur[1], cur[0]});
      cur.delete();
    end
  endfunction

  function automatic void model_flush();
    logic [31:0] w;
    logic [3:0]  k;
    w = '0;
    k = '0;
    if (cur.size() != 0) begin
      for (int i = 0; i < cur.size(); i++) begin
        w[i*8 +: 8] = cur[i];
        k[i]        = 1'b1;
      end
      exp_q.push_back({k, w});
      exp_partials++;
      cur.delete();
    end
  endfunction

  task automatic cycle(input bit ce, input bit rdy, input bit fl);
    @(negedge clk);
    clken        = ce;
    out_ready    = rdy;
    flush        = fl;
    in_empty     = (fifo.size() == 0);
    in_read_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    s_rd   = in_read_en;
    s_vld  = out_valid;
    s_data = out_data;
    s_keep = out_keep;
    s_busy = busy;
    s_hs   = out_valid & rdy & ce;
    if (s_hs) begin
      obs_q.push_back({out_keep, out_data});
      if (out_keep != 4'hF) obs_partials++;
    end
    if (s_rd) begin
      if (fifo.size() == 0) illegal_pops++;
      else model_pop(fifo.pop_front());
    end
    if (fl && ce) model_flush();
  endtask

  task automatic clear_model();
    fifo.delete();
    cur.delete();
    exp_q.delete();
    obs_q.delete();
    exp_partials = 0;
    obs_partials = 0;
    illegal_pops = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset        = 1'b0;
    clken        = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    in_empty     = 1'b1;
    in_read_data = 8'h00;
    clear_model();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clken = 1'b1; in_empty = 1'b0; in_read_data = 8'h5A;
    out_ready = 1'b1; flush = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (in_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b want 0", in_read_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", out_data); end
    checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h want 0", out_keep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (in_read_en !== 1'b1) begin errors++; $display("FAIL reset_release_read_en: got %b want 1", in_read_en); end
    clken = 1'b0;
  endtask

  task automatic test_fill();
    int pops = 0;
    int n = 0;
    do_reset();
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
    while (pops < 4 && n < 10) begin
      cycle(1, 1, 0);
      if (s_rd) pops++;
      n++;
    end
    checks++; if (pops != 4) begin errors++; $display("FAIL fill_pops: got %0d want 4", pops); end
    cycle(1, 1, 0);
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b want 1", s_vld); end
    checks++; if (s_data !== 32'h44332211) begin errors++; $display("FAIL fill_data: got %h want 44332211", s_data); end
    checks++; if (s_keep !== 4'hF) begin errors++; $display("FAIL fill_keep: got %h want f", s_keep); end
    cycle(1, 1, 0);
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL fill_valid_drop: got %b want 0", s_vld); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL fill_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    do_reset();
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (10) begin
      cycle(1, 0, 0);
      if (s_rd) pops++;
    end
    checks++; if (pops != 7) begin errors++; $display("FAIL bp_pops: got %0d want 7", pops); end
    checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL bp_last_lane_stall: got %b want 0", s_rd); end
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b want 1", s_vld); end
    checks++; if (s_data !== 32'h44332211) begin errors++; $display("FAIL bp_data_hold: got %h want 44332211", s_data); end
    cycle(1, 1, 0);
    checks++; if (s_rd !== 1'b1) begin errors++; $display("FAIL bp_release_pop: got %b want 1", s_rd); end
    checks++; if (s_hs !== 1'b1) begin errors++; $display("FAIL bp_release_hs: got %b want 1", s_hs); end
    cycle(1, 1, 0);
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid: got %b want 1", s_vld); end
    checks++; if (s_data !== 32'h88776655) begin errors++; $display("FAIL bp_b2b_data: got %h want 88776655", s_data); end
    checks++; if (s_keep !== 4'hF) begin errors++; $display("FAIL bp_b2b_keep: got %h want f", s_keep); end
  endtask

  task automatic test_partial_flush();
    int n = 0;
    do_reset();
    fifo = '{8'hAA, 8'hBB};
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    s_vld = 1'b0;
    while (!s_vld && n < 10) begin
      cycle(1, 1, 0);
      n++;
    end
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL pflush_valid: got %b want 1", s_vld); end
    checks++; if (s_data !== 32'h0000BBAA) begin errors++; $display("FAIL pflush_data: got %h want 0000bbaa", s_data); end
    checks++; if (s_keep !== 4'h3) begin errors++; $display("FAIL pflush_keep: got %h want 3", s_keep); end
    cycle(1, 1, 0);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL pflush_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_flush_same_cycle();
    int n = 0;
    do_reset();
    fifo = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 1);
    checks++; if (s_rd !== 1'b1) begin errors++; $display("FAIL sflush_pop_taken: got %b want 1", s_rd); end
    cycle(1, 1, 0);
    checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL sflush_no_pop_pending: got %b want 0", s_rd); end
    while (!s_vld && n < 10) begin
      cycle(1, 1, 0);
      n++;
    end
    checks++; if (s_data !== 32'h00CCBBAA) begin errors++; $display("FAIL sflush_data: got %h want 00ccbbaa", s_data); end
    checks++; if (s_keep !== 4'h7) begin errors++; $display("FAIL sflush_keep: got %h want 7", s_keep); end
  endtask

  task automatic test_flush_lane0();
    do_reset();
    cycle(1, 1, 1);
    cycle(1, 1, 0);
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL f0_pending_busy: got %b want 1", s_busy); end
    cycle(1, 1, 0);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL f0_cleared: got %b want 0", s_busy); end
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL f0_no_output: got %b want 0", s_vld); end
  endtask

  task automatic test_async_reset();
    logic [7:0] w[4];
    int n = 0;
    do_reset();
    repeat (7) fifo.push_back(8'($urandom));
    repeat (6) cycle(1, 0, 0);
    #2;
    checks++; if (in_read_en !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got rd=%b vld=%b want 1 1", in_read_en, out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    checks++; if (in_read_en !== 1'b0) begin errors++; $display("FAIL areset_read_en: got %b want 0", in_read_en); end
    @(posedge clk);
    #2 reset = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      fifo.push_back(w[i]);
    end
    s_vld = 1'b0;
    while (!s_vld && n < 12) begin
      cycle(1, 1, 0);
      n++;
    end
    checks++; if (s_data !== {w[3], w[2], w[1], w[0]} || s_keep !== 4'hF) begin
      errors++; $display("FAIL areset_clean_word: got %h/%h want %h/f", s_data, s_keep, {w[3], w[2], w[1], w[0]});
    end
  endtask

  task automatic test_clken();
    logic [7:0] w[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      fifo.push_back(w[i]);
    end
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1);
      checks++; if (s_rd !== 1'b0 || s_busy !== 1'b1 || s_vld !== 1'b0) begin
        errors++; $display("FAIL clken_freeze_fill: got rd=%b busy=%b vld=%b want 0 1 0", s_rd, s_busy, s_vld);
      end
    end
    repeat (6) cycle(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0);
      checks++; if (s_vld !== 1'b1 || s_data !== {w[7], w[6], w[5], w[4]}) begin
        errors++; $display("FAIL clken_freeze_out: got vld=%b %h want 1 %h", s_vld, s_data, {w[7], w[6], w[5], w[4]});
      end
    end
    repeat (2) cycle(1, 1, 0);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL clken_words: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL clken_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cool = 0;
    int n = 0;
    bit ce, rdy, fl;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 55) fifo.push_back(8'($urandom));
      ce  = ($urandom_range(0, 99) < 90);
      rdy = ($urandom_range(0, 99) < 70);
      fl  = ce && cool == 0 && obs_partials == exp_partials && ($urandom_range(0, 99) < 4);
      cycle(ce, rdy, fl);
      if (fl) cool = 2;
      else if (ce && cool > 0) cool--;
    end
    while ((fifo.size() != 0 || cool != 0 || obs_partials != exp_partials) && n < 500) begin
      cycle(1, 1, 0);
      if (cool > 0) cool--;
      n++;
    end
    checks++; if (n >= 500) begin errors++; $display("FAIL rand_drain_timeout: got %0d cycles want <500", n); end
    cycle(1, 1, 1);
    repeat (6) cycle(1, 1, 0);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got busy=%b want 0", s_busy); end
    checks++; if (illegal_pops != 0) begin errors++; $display("FAIL rand_empty_pop: got %0d want 0", illegal_pops); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

`ifdef FWFT_WORD_PACKER_STATS_EN
  task automatic test_stats();
    int n = 0;
    do_reset();
    repeat (14) fifo.push_back(8'($urandom));
    while (fifo.size() != 0 && n < 40) begin
      cycle(1, 1, 0);
      n++;
    end
    repeat (2) cycle(1, 1, 0);
    cycle(1, 1, 1);
    repeat (6) cycle(1, 1, 0);
    checks++; if (word_count !== 32'd4) begin errors++; $display("FAIL stats_words: got %0d want 4", word_count); end
    checks++; if (partial_count !== 16'd1) begin errors++; $display("FAIL stats_partials: got %0d want 1", partial_count); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_partial_flush();
    test_flush_same_cycle();
    test_flush_lane0();
    test_async_reset();
    test_clken();
    test_random();
`ifdef FWFT_WORD_PACKER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
